// File: rtl/seg7_pkg.sv
// Purpose: shared seven-segment glyph table, blank constant and decode helper.
// Latency: n/a (constants and a combinational function only).
// Backpressure: n/a.
// Contents: BLANK, GLYPH_TABLE[16] indexed by hex value, glyph_dec_t, seg7_decode().
package seg7_pkg;

  // Segment order is {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [6:0] BLANK = 7'h00;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       legal;
    logic [3:0] value;
  } glyph_dec_t;

  // Reverse lookup of the glyph table; legal=0 for blank and for any
  // pattern that is not one of the sixteen hex glyphs.
  function automatic glyph_dec_t seg7_decode(input logic [6:0] pat);
    glyph_dec_t d;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      if (pat == GLYPH_TABLE[i]) begin
        d.legal = 1'b1;
        d.value = 4'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_fifo.sv
// Purpose: small synchronous FIFO holding decoded digits.
// Latency: a write is visible at the head one cycle after the write edge.
// Backpressure: head held until out_rdy; a write into a full buffer is
//   dropped (drop=1) unless a pop happens on the same edge.
// Ports: clk, reset (sync, active-high); in_vld/in_dat write side;
//   out_vld/out_rdy/out_dat read side; level occupancy; drop lost-write strobe.
module seg7_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_vld,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             wr;

  assign out_vld = (level != '0);
  assign full    = (level == FULL_LVL);
  assign pop     = out_vld && out_rdy;
  // When full, the slot being popped this edge is the one the write reuses.
  assign wr      = in_vld && (!full || pop);
  assign drop    = in_vld && full && !pop;
  // Head is read straight from storage so it is valid whenever out_vld is.
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && wr) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !wr) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Purpose: sample an asynchronous 7-segment pattern, debounce it and queue decoded hex digits.
// Latency: a new pattern held steady before edge 0 appears on dig_valid after edge STABLE_CYCLES+3.
// Backpressure: digits wait in a FIFO_DEPTH buffer for dig_ready; when full they are dropped and overflow sticks.
// Ports: clk, reset (sync, active-high); seg_in {g,f,e,d,c,b,a}; dig_valid/dig_ready/dig_data
//   head-of-buffer handshake; fifo_level occupancy; err_count illegal-glyph count; overflow sticky drop flag.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [6:0]                    seg_in,
  input  logic                          dig_ready,
  output logic                          dig_valid,
  output logic [3:0]                    dig_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    err_count,
  output logic                          overflow
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [6:0]  seg_s1;
  logic [6:0]  seg_s2;
  logic [6:0]  seg_prev;
  logic [6:0]  last_acc;
  logic [7:0]  stab_cnt;
  logic        push_vld;
  logic [3:0]  push_dat;
  logic        fifo_drop;
  logic        accept;
  glyph_dec_t  dec;

  assign dec = seg7_decode(seg_s2);

  // The saturated counter alone is not enough: on the cycle s2 changes the
  // counter still reflects the old pattern, so also require s2 to match its
  // previous value. Comparing with last_acc makes the event fire only once
  // per distinct stable pattern.
  assign accept = (stab_cnt == CNT_MAX) && (seg_s2 == seg_prev) && (seg_s2 != last_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1    <= BLANK;
      seg_s2    <= BLANK;
      seg_prev  <= BLANK;
      last_acc  <= BLANK;
      stab_cnt  <= '0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;

      if (seg_s2 != seg_prev) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end

      // One register stage between the accept decision and the buffer write.
      push_vld <= accept && dec.legal;
      push_dat <= dec.value;

      if (accept) begin
        last_acc <= seg_s2;
        if (!dec.legal && (seg_s2 != BLANK) && (err_count != 8'hFF)) begin
          err_count <= err_count + 1'b1;
        end
      end

      if (fifo_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  seg7_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (push_vld),
    .in_dat  (push_dat),
    .out_vld (dig_valid),
    .out_rdy (dig_ready),
    .out_dat (dig_data),
    .level   (fifo_level),
    .drop    (fifo_drop)
  );

endmodule

// File: tb/tb_seg7_capture.sv
// Purpose: self-checking bench for seg7_capture against a sample-history reference model.
// Latency: n/a.
// Backpressure: dig_ready driven directly by directed and random stimulus.
module tb_seg7_capture;

  localparam int S = 4;
  localparam int D = 4;

  localparam logic [6:0] REF_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [6:0]            seg_in = 7'h00;
  logic                  dig_ready = 1'b0;
  logic                  dig_valid;
  logic [3:0]            dig_data;
  logic [$clog2(D):0]    fifo_level;
  logic [7:0]            err_count;
  logic                  overflow;

  always #5 clk = ~clk;

  seg7_capture #(
    .STABLE_CYCLES (S),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_in     (seg_in),
    .dig_ready  (dig_ready),
    .dig_valid  (dig_valid),
    .dig_data   (dig_data),
    .fifo_level (fifo_level),
    .err_count  (err_count),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_value(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (REF_GLYPH[i] == p) return i;
    end
    return -1;
  endfunction

  // Reference model: a pattern counts once it has been sampled on S+1
  // consecutive edges and differs from the last counted pattern. Its digit
  // enters the buffer 3 edges later, its error count bump 2 edges later.
  int         cyc = 0;
  int         run_len = 1000;
  logic [6:0] run_val = 7'h00;
  logic [6:0] m_last = 7'h00;
  logic [3:0] m_q [$];
  int         wt_q [$];
  logic [3:0] wd_q [$];
  int         et_q [$];
  int         m_err = 0;
  bit         m_ovf = 1'b0;
  int         m_v;
  logic [3:0] m_d;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_q.delete();
      wt_q.delete();
      wd_q.delete();
      et_q.delete();
      m_err   = 0;
      m_ovf   = 1'b0;
      m_last  = 7'h00;
      run_val = 7'h00;
      run_len = 1000;
    end else begin
      if (m_q.size() != 0 && dig_ready) void'(m_q.pop_front());
      if (wt_q.size() != 0 && wt_q[0] == cyc) begin
        void'(wt_q.pop_front());
        m_d = wd_q.pop_front();
        if (m_q.size() < D) m_q.push_back(m_d);
        else m_ovf = 1'b1;
      end
      if (et_q.size() != 0 && et_q[0] == cyc) begin
        void'(et_q.pop_front());
        if (m_err < 255) m_err++;
      end
      if (seg_in == run_val) run_len++;
      else begin
        run_val = seg_in;
        run_len = 1;
      end
      if (run_len == S + 1 && run_val != m_last) begin
        m_last = run_val;
        m_v = ref_value(run_val);
        if (m_v >= 0) begin
          wt_q.push_back(cyc + 3);
          wd_q.push_back(4'(m_v));
        end else if (run_val != 7'h00) begin
          et_q.push_back(cyc + 2);
        end
      end
    end
  end

  // Inputs change 1 time unit after posedge, so at negedge both the outputs
  // and the dig_ready about to be sampled are stable.
  bit         mon_en = 1'b0;
  logic [3:0] obs_q [$];

  always @(negedge clk) begin
    if (mon_en) begin
      check("m_valid", 32'(dig_valid), 32'(m_q.size() != 0));
      check("m_level", 32'(fifo_level), 32'(m_q.size()));
      if (m_q.size() != 0) check("m_data", 32'(dig_data), 32'(m_q[0]));
      check("m_err", 32'(err_count), 32'(m_err));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
      if (dig_valid && dig_ready) obs_q.push_back(dig_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    tick(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  logic [6:0] ovf_pats [9] = '{7'h06, 7'h00, 7'h5B, 7'h00, 7'h4F, 7'h00, 7'h66, 7'h00, 7'h6D};
  logic [6:0] pat;
  int         r;
  int         len;

  initial begin
    tick(3);
    reset = 1'b0;
    check("rst_valid", 32'(dig_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    mon_en = 1'b1;

    // Basic decode: 0x3F -> digit 0, visible only after edge S+3.
    dig_ready = 1'b1;
    obs_q.delete();
    seg_in = 7'h3F;
    for (int k = 0; k <= 10; k++) begin
      tick(1);
      check($sformatf("basic_vld_e%0d", k), 32'(dig_valid), 32'(k == S + 3));
    end
    check("basic_pops", 32'(obs_q.size()), 32'd1);
    check("basic_dig", 32'(obs_q.size() > 0 ? obs_q[0] : 4'hF), 32'd0);
    check("basic_err", 32'(err_count), 32'd0);

    // Glitch filter: fast 1/2 toggling then a settled 2.
    obs_q.delete();
    for (int i = 0; i < 5; i++) hold((i % 2) ? 7'h5B : 7'h06, 2);
    hold(7'h5B, 12);
    check("glitch_pops", 32'(obs_q.size()), 32'd1);
    check("glitch_dig", 32'(obs_q.size() > 0 ? obs_q[0] : 4'hF), 32'd2);

    // Illegal glyph alternations saturate err_count.
    obs_q.delete();
    for (int i = 0; i < 300; i++) begin
      hold(7'h01, 6);
      hold(7'h00, 6);
    end
    tick(4);
    check("illegal_err", 32'(err_count), 32'd255);
    check("illegal_level", 32'(fifo_level), 32'd0);
    check("illegal_pops", 32'(obs_q.size()), 32'd0);

    // Overflow with the consumer stalled.
    do_reset();
    dig_ready = 1'b0;
    for (int i = 0; i < 9; i++) hold(ovf_pats[i], 8);
    tick(4);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    obs_q.delete();
    dig_ready = 1'b1;
    tick(6);
    dig_ready = 1'b0;
    check("ovf_pops", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovf_order%0d", i), 32'(obs_q.size() > i ? obs_q[i] : 4'hF), 32'(i + 1));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full buffer with a pop on the same edge as the 5th write.
    do_reset();
    dig_ready = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 8; i++) hold(ovf_pats[i], 8);
    seg_in = 7'h6D;
    tick(S + 3);
    dig_ready = 1'b1;
    tick(1);
    dig_ready = 1'b0;
    tick(2);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_level", 32'(fifo_level), 32'd4);
    dig_ready = 1'b1;
    tick(6);
    dig_ready = 1'b0;
    check("fullpop_pops", 32'(obs_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("fullpop_order%0d", i), 32'(obs_q.size() > i ? obs_q[i] : 4'hF), 32'(i + 1));

    // Reset with three buffered digits and a half-qualified pattern.
    do_reset();
    dig_ready = 1'b0;
    hold(7'h01, 8);
    hold(7'h06, 8);
    hold(7'h00, 8);
    hold(7'h5B, 8);
    hold(7'h00, 8);
    hold(7'h4F, 8);
    check("midrst_pre_level", 32'(fifo_level), 32'd3);
    check("midrst_pre_err", 32'(err_count), 32'd1);
    seg_in = 7'h66;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_valid", 32'(dig_valid), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_err", 32'(err_count), 32'd0);
    for (int k = 0; k <= S + 3; k++) begin
      tick(1);
      check($sformatf("midrst_vld_e%0d", k), 32'(dig_valid), 32'(k == S + 3));
    end
    check("midrst_dig", 32'(dig_data), 32'd4);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) pat = REF_GLYPH[$urandom_range(0, 15)];
      else if (r < 8) pat = 7'h00;
      else pat = 7'($urandom);
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 49) == 0) reset = 1'b1;
      seg_in = pat;
      repeat (len) begin
        dig_ready = ($urandom_range(0, 9) < 7);
        tick(1);
      end
      reset = 1'b0;
    end
    dig_ready = 1'b1;
    tick(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive synchronized cycles a segment pattern must hold before it is accepted; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: decoded-digit buffer depth; power of two, 2..16.
REQ-003 clk  input  1  single clock for all state; the wrapper connects wb_clk_i.
REQ-004 reset  input  1  synchronous, active-high reset; the wrapper connects wb_rst_i.
REQ-005 seg_in  input  7  asynchronous segment pattern {g,f,e,d,c,b,a}, 1 = lit, taken from pads io_in[14:8].
REQ-006 dig_ready  input  1  consumer accepts the digit at the head of the buffer.
REQ-007 dig_valid  output  1  buffer non-empty; dig_data is meaningful.
REQ-008 dig_data  output  4  hex value of the head digit.
REQ-009 fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-010 err_count  output  8  count of accepted non-blank patterns that are not legal hex glyphs.
REQ-011 overflow  output  1  sticky flag: a decoded digit was dropped because the buffer was full.

Function
REQ-012 seg_in shall pass through a two-flop synchronizer; s2 is the second-stage output, and all later logic shall use s2 only.
REQ-013 A stability counter shall clear to 0 whenever s2 differs from its previous-cycle value, and shall otherwise increment, saturating at STABLE_CYCLES-1.
REQ-014 An accept event shall occur in the single cycle in which the counter first reaches STABLE_CYCLES-1 and s2 differs from last_accepted; last_accepted then loads s2.
REQ-015 Glyph decode table: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9, 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F.
REQ-016 On accept: a legal glyph pushes its 4-bit value; pattern 0x00 (blank) pushes nothing and changes no counter; any other pattern pushes nothing and increments err_count, which saturates at 255.
REQ-017 A pop shall occur on any rising edge where dig_valid and dig_ready are both 1.
REQ-018 A push into a full buffer shall be accepted only if a pop occurs on the same edge; otherwise the digit is dropped and overflow is set.
REQ-019 Simultaneous push and pop on a non-full, non-empty buffer shall leave fifo_level unchanged.
REQ-020 Read and write pointers shall wrap modulo FIFO_DEPTH; digit order is strictly FIFO.
REQ-021 Latency: for a new pattern applied to seg_in before edge 0, with the buffer empty, dig_valid shall rise after edge STABLE_CYCLES+3.
REQ-022 dig_data shall be driven directly from buffer storage, not from a pop-time register, so the head digit is visible while dig_valid is 1.
REQ-023 Repeating the same glyph requires an intervening different stable pattern, such as blank, before it is pushed again.

Reset
REQ-024 On reset, the synchronizer flops, s2 history and last_accepted shall load 0x00, and the stability counter shall load 0.
REQ-025 On reset, the buffer pointers shall clear, so dig_valid=0 and fifo_level=0; err_count=0 and overflow=0.
REQ-026 Reset asserted mid-qualification or with a non-empty buffer shall discard all pending and buffered digits, with no push on the reset edge.
REQ-027 overflow shall clear only on reset.

Structure
REQ-028 Package seg7_pkg shall hold the 16-entry glyph table, the BLANK constant (0x00), and a decode function returning {legal, value}; segment7 shall use the same table.
REQ-029 The buffer shall be a sub-module seg7_fifo (parameter DEPTH, width 4); synchronizer, qualifier and decode shall live in seg7_capture.

Verification
REQ-030 Basic decode: seg_in=0x3F held 10 cycles with dig_ready=1 -> a single dig_valid pulse with dig_data=0 at cycle 7 after the change; err_count=0.
REQ-031 Glitch filter: seg_in toggles 0x06 -> 0x5B -> 0x06 every 2 cycles, then settles to 0x5B -> exactly one digit 2 is pushed; no digit 1 is pushed.
REQ-032 Illegal glyph and saturation: 300 accepted alternations of 0x01 and 0x00 -> err_count=255; no pushes; fifo_level=0.
REQ-033 Overflow: dig_ready=0; 0x06, 0x00, 0x5B, 0x00, 0x4F, 0x00, 0x66, 0x00, 0x6D, each held 8 cycles -> fifo_level=4, overflow=1, popped order 1,2,3,4.
REQ-034 Full with simultaneous pop: buffer full, dig_ready=1 on the cycle of the 5th accept -> no overflow; level stays 4; the 5th digit is retained.
REQ-035 Reset mid-operation: reset with fifo_level=3 and a pattern half-qualified -> next cycle dig_valid=0, level=0, err_count=0; the same pattern still on seg_in is re-qualified and pushed STABLE_CYCLES+3 cycles after reset deasserts.
